// File: rtl/bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module : bcd_conv_scheduler
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ sources.
// Rev    : 1.0
// ============================================================================
module bcd_conv_scheduler #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64,
    parameter int MAX_VAL = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_num,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_id,
    output logic [3:0]           resp_millares,
    output logic [3:0]           resp_centenas,
    output logic [3:0]           resp_decenas,
    output logic [3:0]           resp_unidades,
    output logic                 resp_ovf,
    output logic                 resp_err,
    output logic [15:0]          bcd_numero,
    input  logic                 bcd_listo,
    input  logic [3:0]           bcd_millares_i,
    input  logic [3:0]           bcd_centenas_i,
    input  logic [3:0]           bcd_decenas_i,
    input  logic [3:0]           bcd_unidades_i
);

    localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [15:0]        c_max_val  = 16'(MAX_VAL);
    localparam logic [1:0]         c_last_req = 2'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_DISCARD = 2'd1,
        S_WAIT_CAPTURE = 2'd2,
        S_RESP         = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_rr;
    logic [1:0]          r_id;
    logic                r_ovf;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          w_gnt;
    logic [1:0]          w_gnt_inc;
    logic [2:0]          w_idx;
    logic                w_found;
    logic [3:0]          w_valid4;
    logic [3:0]          w_onehot;
    logic [63:0]         w_num64;
    logic [15:0]         w_sel_num;
    logic                w_clamp;
    logic                w_accept;
    logic                w_discard;
    logic                w_capture;
    logic                w_timeout;
    logic                w_waiting;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_valid4 = 4'(req_valid);
        w_found  = 1'b0;
        w_gnt    = 2'd0;
        w_idx    = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = 3'(r_rr) + 3'(i);
            if (w_idx >= 3'(N_REQ)) begin
                w_idx = w_idx - 3'(N_REQ);
            end
            if (!w_found && w_valid4[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[1:0];
            end
        end
    end

    assign w_num64   = 64'(req_num);
    assign w_sel_num = w_num64[{w_gnt, 4'b0000} +: 16];
    assign w_clamp   = (w_sel_num > c_max_val);
    assign w_onehot  = 4'b0001 << w_gnt;
    assign w_gnt_inc = (w_gnt == c_last_req) ? 2'd0 : w_gnt + 2'd1;
    assign w_waiting = (r_state == S_WAIT_DISCARD) || (r_state == S_WAIT_CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_discard   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) begin
                    req_ready   = N_REQ'(w_onehot);
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT_DISCARD;
                end
            end
            S_WAIT_DISCARD: begin
                // This pulse closes a conversion sampled before the new value.
                if (bcd_listo) begin
                    w_discard   = 1'b1;
                    w_state_nxt = S_WAIT_CAPTURE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_WAIT_CAPTURE: begin
                if (bcd_listo) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign resp_valid = (r_state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr          <= 2'd0;
            r_id          <= 2'd0;
            r_ovf         <= 1'b0;
            r_cnt         <= '0;
            bcd_numero    <= 16'd0;
            resp_id       <= 2'd0;
            resp_millares <= 4'd0;
            resp_centenas <= 4'd0;
            resp_decenas  <= 4'd0;
            resp_unidades <= 4'd0;
            resp_ovf      <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id       <= w_gnt;
                r_ovf      <= w_clamp;
                r_rr       <= w_gnt_inc;
                bcd_numero <= w_clamp ? c_max_val : w_sel_num;
            end

            if (w_accept || w_discard) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                resp_id       <= r_id;
                resp_ovf      <= r_ovf;
                resp_err      <= 1'b0;
                resp_millares <= bcd_millares_i;
                resp_centenas <= bcd_centenas_i;
                resp_decenas  <= bcd_decenas_i;
                resp_unidades <= bcd_unidades_i;
            end else if (w_timeout) begin
                resp_id       <= r_id;
                resp_ovf      <= r_ovf;
                resp_err      <= 1'b1;
                resp_millares <= 4'd0;
                resp_centenas <= 4'd0;
                resp_decenas  <= 4'd0;
                resp_unidades <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_conv_scheduler
// Directed self-checking bench with a periodic behavioural BCD converter.
// Rev    : 1.0
// ============================================================================
module tb_bcd_conv_scheduler;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [16*N_REQ-1:0] req_num = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [1:0]          resp_id;
    logic [3:0]          resp_millares, resp_centenas, resp_decenas, resp_unidades;
    logic                resp_ovf, resp_err;
    logic [15:0]         bcd_numero;
    logic                bcd_listo;
    logic [3:0]          bcd_millares_i, bcd_centenas_i, bcd_decenas_i, bcd_unidades_i;
    logic [15:0]         digits;

    logic                listo_en = 1'b1;
    logic [2:0]          conv_cnt;
    logic [15:0]         conv_sample;

    int cyc = 0;
    int listo_total = 0;
    int total = 0;
    int bad = 0;

    bcd_conv_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .MAX_VAL(9999)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_millares(resp_millares), .resp_centenas(resp_centenas),
        .resp_decenas(resp_decenas), .resp_unidades(resp_unidades),
        .resp_ovf(resp_ovf), .resp_err(resp_err),
        .bcd_numero(bcd_numero), .bcd_listo(bcd_listo),
        .bcd_millares_i(bcd_millares_i), .bcd_centenas_i(bcd_centenas_i),
        .bcd_decenas_i(bcd_decenas_i), .bcd_unidades_i(bcd_unidades_i)
    );

    always #5 clk = ~clk;

    assign digits = {resp_millares, resp_centenas, resp_decenas, resp_unidades};

    // Converter: pulses every 8 cycles, samples its input on the pulse and
    // shows the digits of the previous sample during the pulse.
    assign bcd_listo      = listo_en && (conv_cnt == 3'd7);
    assign bcd_millares_i = 4'((32'(conv_sample) / 1000) % 10);
    assign bcd_centenas_i = 4'((32'(conv_sample) / 100) % 10);
    assign bcd_decenas_i  = 4'((32'(conv_sample) / 10) % 10);
    assign bcd_unidades_i = 4'(32'(conv_sample) % 10);

    always @(posedge clk) begin
        if (rst) begin
            conv_cnt    <= 3'd0;
            conv_sample <= 16'd0;
        end else begin
            conv_cnt <= conv_cnt + 3'd1;
            if (bcd_listo) conv_sample <= bcd_numero;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bcd_listo) listo_total <= listo_total + 1;
    end

    task automatic issue(input int idx, input logic [15:0] val,
                         output bit ok, output int acc_cyc, output int acc_listo);
        ok = 1'b0;
        @(negedge clk);
        req_num[16*idx +: 16] = val;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            #1;
            if (req_ready[idx]) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        req_valid[idx] = 1'b0;
        acc_cyc   = cyc;
        acc_listo = listo_total;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            if (resp_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        total++; if (bcd_numero !== 16'd0) begin bad++; $display("FAIL reset_numero: got %0d want 0", bcd_numero); end
        total++; if ({resp_id, digits, resp_ovf, resp_err} !== 20'h0) begin
            bad++; $display("FAIL reset_resp: got id=%0d dig=%h ovf=%b err=%b want all 0", resp_id, digits, resp_ovf, resp_err);
        end
    endtask

    task automatic test_single();
        bit ok; int ac, al;
        issue(0, 16'd1234, ok, ac, al);
        total++; if (!ok) begin bad++; $display("FAIL single_accept: got no req_ready want accept"); end
        wait_resp(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_resp: got no resp_valid want response"); end
        total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", resp_id); end
        total++; if (digits !== 16'h1234) begin bad++; $display("FAIL single_digits: got %h want 1234", digits); end
        total++; if ({resp_ovf, resp_err} !== 2'b00) begin bad++; $display("FAIL single_flags: got ovf=%b err=%b want 0 0", resp_ovf, resp_err); end
        total++; if (listo_total - al !== 2) begin bad++; $display("FAIL single_latency: got %0d listo pulses want 2", listo_total - al); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_release: got resp_valid=%b want 0", resp_valid); end
    endtask

    task automatic test_clamp();
        bit ok; int ac, al;
        issue(1, 16'd12000, ok, ac, al);
        total++; if (bcd_numero !== 16'd9999) begin bad++; $display("FAIL clamp_numero: got %0d want 9999", bcd_numero); end
        wait_resp(ok);
        total++; if (!ok) begin bad++; $display("FAIL clamp_resp: got no resp_valid want response"); end
        total++; if (digits !== 16'h9999) begin bad++; $display("FAIL clamp_digits: got %h want 9999", digits); end
        total++; if ({resp_id, resp_ovf, resp_err} !== 4'b0110) begin
            bad++; $display("FAIL clamp_flags: got id=%0d ovf=%b err=%b want 1 1 0", resp_id, resp_ovf, resp_err);
        end
        @(negedge clk);
        issue(0, 16'd0, ok, ac, al);
        total++; if (bcd_numero !== 16'd0) begin bad++; $display("FAIL zero_numero: got %0d want 0", bcd_numero); end
        wait_resp(ok);
        total++; if (digits !== 16'h0000 || resp_ovf !== 1'b0 || resp_id !== 2'd0) begin
            bad++; $display("FAIL zero_resp: got dig=%h ovf=%b id=%0d want 0000 0 0", digits, resp_ovf, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int nresp;
        logic [1:0]       ids  [4];
        logic [15:0]      digs [4];
        logic [15:0]      exp_d[4] = '{16'h0011, 16'h0022, 16'h0011, 16'h0022};
        logic [1:0]       exp_i[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        logic [N_REQ-1:0] prev = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        req_num   = {16'd22, 16'd11};
        req_valid = 2'b11;
        for (int k = 0; k < 600 && nresp < 4; k++) begin
            #1;
            total++; if ($countones(req_ready) > 1 || (req_ready != 0 && prev != 0)) begin
                bad++; $display("FAIL rr_ready_shape: got %b after %b want one-hot single-cycle", req_ready, prev);
            end
            prev = req_ready;
            if (resp_valid) begin
                ids[nresp]  = resp_id;
                digs[nresp] = digits;
                nresp++;
                if (nresp == 4) req_valid = '0;
            end
            @(negedge clk);
        end
        total++; if (nresp !== 4) begin bad++; $display("FAIL rr_count: got %0d responses want 4", nresp); end
        for (int i = 0; i < nresp; i++) begin
            total++; if (ids[i] !== exp_i[i] || digs[i] !== exp_d[i]) begin
                bad++; $display("FAIL rr_resp%0d: got id=%0d dig=%h want id=%0d dig=%h", i, ids[i], digs[i], exp_i[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int ac, al; int errs;
        resp_ready = 1'b0;
        issue(0, 16'd507, ok, ac, al);
        req_num[31:16] = 16'd3;
        req_valid[1]   = 1'b1;
        wait_resp(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_resp: got no resp_valid want response"); end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            total++; if (resp_valid !== 1'b1 || digits !== 16'h0507 || resp_id !== 2'd0 || req_ready !== 2'b00) begin
                bad++; $display("FAIL bp_hold: got v=%b dig=%h id=%0d rdy=%b want 1 0507 0 00", resp_valid, digits, resp_id, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++; if (resp_valid !== 1'b0 || req_ready !== 2'b10) begin
            bad++; $display("FAIL bp_release: got v=%b rdy=%b want 0 10", resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp(ok);
        total++; if (resp_id !== 2'd1 || digits !== 16'h0003) begin
            bad++; $display("FAIL bp_next: got id=%0d dig=%h want 1 0003", resp_id, digits);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int ac, al;
        listo_en = 1'b0;
        issue(0, 16'd20000, ok, ac, al);
        total++; if (bcd_numero !== 16'd9999) begin bad++; $display("FAIL to_numero: got %0d want 9999", bcd_numero); end
        wait_resp(ok);
        total++; if (cyc - ac !== TIMEOUT) begin bad++; $display("FAIL to_latency: got %0d cycles want %0d", cyc - ac, TIMEOUT); end
        total++; if ({resp_err, resp_ovf} !== 2'b11 || digits !== 16'h0000 || resp_id !== 2'd0) begin
            bad++; $display("FAIL to_resp: got err=%b ovf=%b dig=%h id=%0d want 1 1 0000 0", resp_err, resp_ovf, digits, resp_id);
        end
        @(negedge clk);
        listo_en = 1'b1;
        issue(1, 16'd4321, ok, ac, al);
        wait_resp(ok);
        total++; if ({resp_err, resp_ovf} !== 2'b00 || digits !== 16'h4321 || resp_id !== 2'd1) begin
            bad++; $display("FAIL to_recover: got err=%b ovf=%b dig=%h id=%0d want 0 0 4321 1", resp_err, resp_ovf, digits, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; int ac, al;
        issue(0, 16'd9000, ok, ac, al);
        for (int k = 0; k < 100 && (listo_total - al) < 1; k++) @(negedge clk);
        total++; if (listo_total - al !== 1) begin bad++; $display("FAIL mid_discard: got %0d pulses want 1", listo_total - al); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0 || bcd_numero !== 16'd0 || {resp_id, digits, resp_ovf, resp_err} !== 20'h0) begin
            bad++; $display("FAIL mid_outputs: got v=%b num=%0d dig=%h want all 0", resp_valid, bcd_numero, digits);
        end
        req_num[31:16] = 16'd42;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_rr_ptr: got %b want 01", req_ready); end
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mid_grant1: got %b want 10", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(ok);
        total++; if (!ok || resp_id !== 2'd1 || digits !== 16'h0042) begin
            bad++; $display("FAIL mid_after: got id=%0d dig=%h want 1 0042", resp_id, digits);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
